debug_ocimem_arbiter: RTL

- Controller for the debug module's single-port on-chip debug memory/register file (OCI RAM).
- Shares the RAM between two requesters:
  - the JTAG command path, which is pulse-strobed from the debug-slave sysclk logic;
  - the CPU debug monitor, through an Avalon-style port with waitrequest.
- Sequences each access: grant, RAM drive, read-data capture into the monitor data register, completion.
- Enforces the halted-CPU rule on JTAG accesses and reports dropped or refused commands.

---
 rtl/debug_ocimem_arbiter_pkg.sv | 18 +
 rtl/debug_ocimem_arbiter_if.sv | 49 ++++
 rtl/debug_ocimem_arbiter_rr_arb.sv | 30 +++
 rtl/debug_ocimem_arbiter.sv | 137 +++++++++++++
 4 files changed

// File: rtl/debug_ocimem_arbiter_pkg.sv
// rtl/debug_ocimem_arbiter_pkg.sv - shared types and default widths for the OCI RAM arbiter
package debug_ocimem_arbiter_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RDATA  = 2'd2
    } state_t;

    typedef enum logic {
        REQ_CPU  = 1'b0,
        REQ_JTAG = 1'b1
    } req_id_t;

endpackage

// File: rtl/debug_ocimem_arbiter_if.sv
// rtl/debug_ocimem_arbiter_if.sv - JTAG command, CPU Avalon and OCI RAM signal bundle
interface debug_ocimem_arbiter_if
    import debug_ocimem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              jtag_cmd_valid;
    logic              jtag_cmd_wr;
    logic [ADDR_W-1:0] jtag_cmd_addr;
    logic              jtag_cmd_autoinc;
    logic [DATA_W-1:0] jtag_wdata;
    logic              debugack;
    logic              jtag_done;
    logic              jtag_err;
    logic              jtag_err_clr;
    logic [DATA_W-1:0] mon_dreg;
    logic              cpu_read;
    logic              cpu_write;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_waitrequest;
    logic [DATA_W-1:0] cpu_readdata;
    logic              cpu_readdatavalid;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  jtag_cmd_valid, jtag_cmd_wr, jtag_cmd_addr, jtag_cmd_autoinc, jtag_wdata,
        input  debugack, jtag_err_clr,
        input  cpu_read, cpu_write, cpu_addr, cpu_wdata,
        input  ram_rdata,
        output jtag_done, jtag_err, mon_dreg,
        output cpu_waitrequest, cpu_readdata, cpu_readdatavalid,
        output ram_addr, ram_wren, ram_wdata
    );

    modport master (
        output jtag_cmd_valid, jtag_cmd_wr, jtag_cmd_addr, jtag_cmd_autoinc, jtag_wdata,
        output debugack, jtag_err_clr,
        output cpu_read, cpu_write, cpu_addr, cpu_wdata,
        output ram_rdata,
        input  jtag_done, jtag_err, mon_dreg,
        input  cpu_waitrequest, cpu_readdata, cpu_readdatavalid,
        input  ram_addr, ram_wren, ram_wdata
    );
endinterface

// File: rtl/debug_ocimem_arbiter_rr_arb.sv
// rtl/debug_ocimem_arbiter_rr_arb.sv - two-way round-robin grant holding the last winner
module debug_ocimem_rr_arb
    import debug_ocimem_arbiter_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    req_cpu,
    input  logic    req_jtag,
    output req_id_t grant,
    output logic    grant_valid
);
    req_id_t last_grant;

    always_comb begin
        grant = REQ_CPU;
        if (req_cpu && req_jtag)
            grant = (last_grant == REQ_CPU) ? REQ_JTAG : REQ_CPU;
        else if (req_jtag)
            grant = REQ_JTAG;
    end

    assign grant_valid = req_cpu || req_jtag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant <= REQ_CPU;
        else if (grant_valid)
            last_grant <= grant;
    end
endmodule

// File: rtl/debug_ocimem_arbiter.sv
// rtl/debug_ocimem_arbiter.sv - shares the OCI RAM between the JTAG command path and the CPU monitor
module debug_ocimem_arbiter
    import debug_ocimem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
)(
    input logic                  clk,
    input logic                  reset,
    debug_ocimem_arbiter_if.slave bus
);
    state_t            state;
    req_id_t           cur_req;
    logic              cur_wr;
    logic              pend;
    logic              pend_wr;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_wdata;
    logic [ADDR_W-1:0] inc_addr;

    logic              cpu_req;
    logic              jtag_req;
    logic              grant_valid;
    req_id_t           grant;
    logic              jtag_grant;
    logic              refuse;
    logic              strobe_load;
    logic              drop;
    logic [ADDR_W-1:0] next_inc;
    logic [ADDR_W-1:0] load_addr;

    assign cpu_req  = (state == ST_IDLE) && (bus.cpu_read || bus.cpu_write);
    assign jtag_req = (state == ST_IDLE) && pend;

    debug_ocimem_rr_arb u_arb (
        .clk         (clk),
        .rst         (reset),
        .req_cpu     (cpu_req),
        .req_jtag    (jtag_req),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign jtag_grant = grant_valid && (grant == REQ_JTAG);
    assign refuse     = jtag_grant && !bus.debugack;
    // A strobe landing on the cycle the pending slot is granted refills it instead of overflowing
    assign strobe_load = bus.jtag_cmd_valid && (!pend || jtag_grant);
    assign drop        = bus.jtag_cmd_valid && pend && !jtag_grant;
    // Forward the post-increment address so an autoinc strobe coinciding with a grant sees it
    assign next_inc    = (jtag_grant && bus.debugack) ? pend_addr + ADDR_W'(1) : inc_addr;
    assign load_addr   = bus.jtag_cmd_autoinc ? next_inc : bus.jtag_cmd_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                 <= ST_IDLE;
            cur_req               <= REQ_CPU;
            cur_wr                <= 1'b0;
            pend                  <= 1'b0;
            pend_wr               <= 1'b0;
            pend_addr             <= '0;
            pend_wdata            <= '0;
            inc_addr              <= '0;
            bus.jtag_done         <= 1'b0;
            bus.jtag_err          <= 1'b0;
            bus.mon_dreg          <= '0;
            bus.cpu_waitrequest   <= 1'b1;
            bus.cpu_readdata      <= '0;
            bus.cpu_readdatavalid <= 1'b0;
            bus.ram_addr          <= '0;
            bus.ram_wren          <= 1'b0;
            bus.ram_wdata         <= '0;
        end else begin
            bus.jtag_done         <= 1'b0;
            bus.cpu_readdatavalid <= 1'b0;
            inc_addr              <= next_inc;

            if (drop || refuse)
                bus.jtag_err <= 1'b1;
            else if (bus.jtag_err_clr)
                bus.jtag_err <= 1'b0;

            if (strobe_load) begin
                pend       <= 1'b1;
                pend_wr    <= bus.jtag_cmd_wr;
                pend_addr  <= load_addr;
                pend_wdata <= bus.jtag_wdata;
            end else if (jtag_grant) begin
                pend <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (refuse) begin
                        bus.jtag_done <= 1'b1;
                    end else if (jtag_grant) begin
                        state         <= ST_ACCESS;
                        cur_req       <= REQ_JTAG;
                        cur_wr        <= pend_wr;
                        bus.ram_addr  <= pend_addr;
                        bus.ram_wdata <= pend_wdata;
                        bus.ram_wren  <= pend_wr;
                    end else if (grant_valid) begin
                        state               <= ST_ACCESS;
                        cur_req             <= REQ_CPU;
                        cur_wr              <= bus.cpu_write;
                        bus.ram_addr        <= bus.cpu_addr;
                        bus.ram_wdata       <= bus.cpu_wdata;
                        bus.ram_wren        <= bus.cpu_write;
                        bus.cpu_waitrequest <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    bus.ram_wren        <= 1'b0;
                    bus.cpu_waitrequest <= 1'b1;
                    if (cur_wr) begin
                        state <= ST_IDLE;
                        if (cur_req == REQ_JTAG)
                            bus.jtag_done <= 1'b1;
                    end else begin
                        state <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    state <= ST_IDLE;
                    if (cur_req == REQ_JTAG) begin
                        bus.mon_dreg  <= bus.ram_rdata;
                        bus.jtag_done <= 1'b1;
                    end else begin
                        bus.cpu_readdata      <= bus.ram_rdata;
                        bus.cpu_readdatavalid <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
